// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared LDPC front-end constants, LLR type, FSM states
// and the round/shift/clip step used by every LLR producer.
package ldpc_pkg;

  localparam int LDPC_CODEWORD_LENGTH = 2304;
  localparam int LLR_W = 8;

  typedef logic signed [LLR_W-1:0] llr_t;

  typedef enum logic {
    SYNC,
    FRAME
  } framer_state_t;

  function automatic logic signed [31:0] llr_round_shift(
    input logic signed [31:0] value,
    input int shift
  );
    logic signed [31:0] r;
    r = value;
    if (shift > 0) r = r + (32'sd1 <<< (shift - 1));
    return r >>> shift;
  endfunction

  // Symmetric clip: the most negative code is never produced.
  function automatic logic signed [31:0] llr_saturate(
    input logic signed [31:0] value,
    input int shift,
    input int out_w = LLR_W
  );
    logic signed [31:0] r;
    logic signed [31:0] lim;
    r = llr_round_shift(value, shift);
    lim = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    if (r > lim) r = lim;
    else if (r < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/ldpc_skid_buffer.sv
// ldpc_skid_buffer: 2-entry valid/ready register slice with a
// registered ready, giving full throughput and no combinational paths.
module ldpc_skid_buffer #(
  parameter int W = 9
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic         out_vld_q, out_vld_d;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         rdy_q, rdy_d;
  logic         in_fire;
  logic         out_free;

  always_comb begin
    in_fire    = i_valid & rdy_q;
    out_free   = !out_vld_q | i_ready;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) out_dat_d = i_data;
      end
    end else if (in_fire) begin
      // Output stalled: park the new beat in the skid entry.
      skid_vld_d = 1'b1;
      skid_dat_d = i_data;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      rdy_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      rdy_q      <= rdy_d;
    end
  end

  assign o_ready = rdy_q;
  assign o_valid = out_vld_q;
  assign o_data  = out_dat_q;

endmodule

// File: rtl/ldpc_llr_framer.sv
// ldpc_llr_framer: soft sample -> saturated LLR, framed into codewords.
// Optional per-codeword clip counter: LDPC_LLR_FRAMER_SAT_STATS_EN.
module ldpc_llr_framer
  import ldpc_pkg::*;
#(
  parameter int IN_WIDTH        = 16,
  parameter int OUT_WIDTH       = LLR_W,
  parameter int CODEWORD_LENGTH = LDPC_CODEWORD_LENGTH,
  parameter int SHIFT           = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [IN_WIDTH-1:0]  i_in_data,
  input  logic                 i_in_sof,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [OUT_WIDTH-1:0] o_out_data,
  output logic                 o_out_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
`ifdef LDPC_LLR_FRAMER_SAT_STATS_EN
  output logic [15:0]          o_sat_count,
`endif
  output logic [15:0]          o_frame_count,
  output logic                 o_sof_error
);

  localparam int IDX_W =
    (CODEWORD_LENGTH > 1) ? $clog2(CODEWORD_LENGTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODEWORD_LENGTH - 1);

  framer_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] beat_idx;
  logic             err_q, err_d;
  logic [15:0]      fc_q, fc_d;
  logic             accept;
  logic             push;
  logic             beat_last;
  logic             out_fire;
  logic             sb_ready;
  logic             sb_valid;
  logic [OUT_WIDTH:0] sb_in;
  logic [OUT_WIDTH:0] sb_out;
  logic signed [31:0] ext;
  logic signed [31:0] shifted;
  logic signed [31:0] sat_val;
  logic               clipped;

  always_comb begin
    ext     = 32'(signed'(i_in_data));
    shifted = llr_round_shift(ext, SHIFT);
    sat_val = llr_saturate(ext, SHIFT, OUT_WIDTH);
    clipped = (shifted != sat_val);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    push     = 1'b0;
    beat_idx = idx_q;
    accept   = i_in_valid & sb_ready;
    unique case (state_q)
      SYNC: begin
        if (accept && i_in_sof) begin
          push     = 1'b1;
          beat_idx = '0;
          state_d  = FRAME;
        end
      end
      FRAME: begin
        if (accept) begin
          push = 1'b1;
          // Early sof abandons the codeword; late sof is tolerated.
          if (i_in_sof && idx_q != '0) begin
            err_d    = 1'b1;
            beat_idx = '0;
          end else if (!i_in_sof && idx_q == '0) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
    beat_last = (beat_idx == IDX_LAST);
    if (push) begin
      idx_d = beat_last ? '0 : beat_idx + IDX_W'(1);
    end
    sb_in = {beat_last, sat_val[OUT_WIDTH-1:0]};
  end

  always_comb begin
    out_fire = sb_valid & i_out_ready;
    fc_d     = fc_q;
    if (out_fire && sb_out[OUT_WIDTH]) fc_d = fc_q + 16'd1;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= SYNC;
      idx_q   <= '0;
      err_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
    end
  end

  ldpc_skid_buffer #(
    .W(OUT_WIDTH + 1)
  ) u_skid (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_data   (sb_in),
    .i_valid  (push),
    .o_ready  (sb_ready),
    .o_data   (sb_out),
    .o_valid  (sb_valid),
    .i_ready  (i_out_ready)
  );

`ifdef LDPC_LLR_FRAMER_SAT_STATS_EN
  logic [15:0] sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (push) begin
      if (beat_idx == '0) sat_d = {15'd0, clipped};
      else if (clipped && sat_q != 16'hFFFF) sat_d = sat_q + 16'd1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) sat_q <= '0;
    else            sat_q <= sat_d;
  end

  assign o_sat_count = sat_q;
`endif

  assign o_in_ready    = sb_ready;
  assign o_out_valid   = sb_valid;
  assign o_out_data    = sb_out[OUT_WIDTH-1:0];
  assign o_out_last    = sb_out[OUT_WIDTH];
  assign o_frame_count = fc_q;
  assign o_sof_error   = err_q;

endmodule

// File: tb/tb_ldpc_llr_framer.sv
// tb_ldpc_llr_framer: directed vectors with hand-computed LLRs,
// an expected-output queue and frame/error counters.
module tb_ldpc_llr_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_in_data = '0;
  logic        i_in_sof = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [7:0]  o_out_data;
  logic        o_out_last;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [15:0] o_frame_count;
  logic        o_sof_error;
`ifdef LDPC_LLR_FRAMER_SAT_STATS_EN
  logic [15:0] o_sat_count;
`endif

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int bp_mode = 0;
  bit live = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  ldpc_llr_framer dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_in_data    (i_in_data),
    .i_in_sof     (i_in_sof),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_out_data   (o_out_data),
    .o_out_last   (o_out_last),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
`ifdef LDPC_LLR_FRAMER_SAT_STATS_EN
    .o_sat_count  (o_sat_count),
`endif
    .o_frame_count(o_frame_count),
    .o_sof_error  (o_sof_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: i_out_ready = 1'b1;
        1: i_out_ready = 1'($urandom_range(1, 0));
        default: i_out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (o_sof_error) err_cnt++;
      if (live && !o_in_ready)
        check_eq("rdy_low_only_when_full", 32'(o_out_valid), 32'd1);
      if (o_out_valid && i_out_ready) begin
        check_eq("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("out_beat", {23'd0, o_out_last, o_out_data}, {23'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [15:0] s, input logic sof,
                      input logic emit, input logic [7:0] exp,
                      input logic last);
    int n = 0;
    logic acc;
    i_in_data  = s;
    i_in_sof   = sof;
    i_in_valid = 1'b1;
    forever begin
      acc = o_in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        check_eq("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    if (emit) exp_q.push_back({last, exp});
    i_in_valid = 1'b0;
    i_in_sof   = 1'b0;
  endtask

  task automatic send_run(input int n, input logic first_sof,
                          input int last_at);
    for (int i = 0; i < n; i++) begin
      send(16'((i % 100) << 4), (i == 0) ? first_sof : 1'b0, 1'b1,
           8'(i % 100), i == last_at);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    live  = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(o_out_valid), 32'd0);
    check_eq("rst_out_last", 32'(o_out_last), 32'd0);
    check_eq("rst_out_data", 32'(o_out_data), 32'd0);
    check_eq("rst_in_ready", 32'(o_in_ready), 32'd0);
    check_eq("rst_frame_count", 32'(o_frame_count), 32'd0);
    check_eq("rst_sof_error", 32'(o_sof_error), 32'd0);
    exp_q.delete();
    i_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    live = 1'b1;
    check_eq("first_ready", 32'(o_in_ready), 32'd1);
  endtask

  logic [15:0] rnd_in[5];
  logic [7:0]  rnd_exp[5];
  int e0;

  initial begin
    rnd_in  = '{16'h0038, 16'hFFE8, 16'h0007, 16'h7FFF, 16'h8000};
    rnd_exp = '{8'h04, 8'hFF, 8'h00, 8'h7F, 8'h81};
    do_reset();

    for (int i = 0; i < 5; i++) begin
      send(rnd_in[i], i == 0, 1'b1, rnd_exp[i], 1'b0);
      check_eq($sformatf("lat1_valid_%0d", i), 32'(o_out_valid), 32'd1);
      check_eq($sformatf("round_sat_%0d", i), 32'(o_out_data),
               32'(rnd_exp[i]));
      @(posedge clk);
      #1;
    end
    drain();

    do_reset();
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) send(16'h0050, 1'b0, 1'b0, 8'h00, 1'b0);
    send_run(2304, 1'b1, 2303);
    drain();
    check_eq("frame_cnt_1", 32'(o_frame_count), 32'd1);
    check_eq("frame_no_err", 32'(err_cnt - e0), 32'd0);

    do_reset();
    e0 = err_cnt;
    bp_mode = 1;
    send_run(2304, 1'b1, 2303);
    send_run(2304, 1'b1, 2303);
    drain();
    bp_mode = 0;
    check_eq("bp_frame_cnt_2", 32'(o_frame_count), 32'd2);
    check_eq("bp_no_err", 32'(err_cnt - e0), 32'd0);

    e0 = err_cnt;
    send_run(1000, 1'b1, -1);
    send_run(2304, 1'b1, 2303);
    drain();
    check_eq("early_sof_err", 32'(err_cnt - e0), 32'd1);
    check_eq("early_sof_frames", 32'(o_frame_count), 32'd3);

    e0 = err_cnt;
    send_run(2304, 1'b0, 2303);
    drain();
    check_eq("miss_sof_err", 32'(err_cnt - e0), 32'd1);
    check_eq("miss_sof_frames", 32'(o_frame_count), 32'd4);

    bp_mode = 2;
    send(16'h0010, 1'b1, 1'b1, 8'h01, 1'b0);
    send(16'h0020, 1'b0, 1'b1, 8'h02, 1'b0);
    @(posedge clk);
    #1;
    check_eq("pre_rst_valid", 32'(o_out_valid), 32'd1);
    do_reset();
    bp_mode = 0;
    for (int i = 0; i < 3; i++) send(16'h0030, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("sync_discard", 32'(o_out_valid), 32'd0);
    send(16'h0040, 1'b1, 1'b1, 8'h04, 1'b0);
    check_eq("resync_data", 32'(o_out_data), 32'h04);
    drain();
    check_eq("post_rst_frames", 32'(o_frame_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
